// File: rtl/cache_pkg.sv
// Shared defaults and helpers for the cache data fetcher: geometry constants,
// the way-index type and a one-hot test used on both the read and fill paths.
package cache_pkg;

    localparam int DEF_NUM_WAYS   = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_SETS   = 16;

    // Widest way vector the one-hot helper accepts; narrower vectors are zero-padded.
    localparam int MAX_WAYS = 32;

    typedef logic [$clog2(DEF_NUM_WAYS)-1:0] way_idx_t;

    function automatic logic is_onehot(input logic [MAX_WAYS-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/onehot_to_index.sv
// Converts a one-hot way vector to a binary way index and flags whether the
// vector really was one-hot (index is meaningless when o_valid is 0).
module onehot_to_index
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic [NUM_WAYS-1:0] i_onehot,
    output logic [WAY_W-1:0]    o_index,
    output logic                o_valid
);

    logic [MAX_WAYS-1:0] w_padded;
    logic [WAY_W-1:0]    w_index;

    always_comb begin
        w_padded = '0;
        w_padded[NUM_WAYS-1:0] = i_onehot;
    end

    always_comb begin
        w_index = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (i_onehot[i]) begin
                w_index = w_index | WAY_W'(i);
            end
        end
    end

    assign o_index = w_index;
    assign o_valid = is_onehot(w_padded);

endmodule

// File: rtl/cache_data_fetcher.sv
// Way/set addressed data store with a 1-cycle read port and a fill write port.
// Handshake: req_valid has no backpressure; every request yields exactly one data_valid pulse the next cycle.
module cache_data_fetcher
    import cache_pkg::*;
#(
    parameter int NUM_WAYS   = DEF_NUM_WAYS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_SETS   = DEF_NUM_SETS,
    parameter int SET_W      = $clog2(NUM_SETS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [SET_W-1:0]      set_idx,
    input  logic [NUM_WAYS-1:0]   targetWay,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  data_valid,
    output logic                  onehot_err,
    input  logic                  wr_en,
    input  logic [NUM_WAYS-1:0]   wr_way,
    input  logic [SET_W-1:0]      wr_set,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_err
);

    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic [DATA_WIDTH-1:0] r_mem [NUM_WAYS][NUM_SETS];
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_oh_err;
    logic                  r_wr_err;

    logic [WAY_W-1:0] w_rd_idx;
    logic [WAY_W-1:0] w_wr_idx;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic             w_wr_go;
    logic             w_bypass;

    onehot_to_index #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_rd_idx (
        .i_onehot (targetWay),
        .o_index  (w_rd_idx),
        .o_valid  (w_rd_ok)
    );

    onehot_to_index #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_wr_idx (
        .i_onehot (wr_way),
        .o_index  (w_wr_idx),
        .o_valid  (w_wr_ok)
    );

    assign w_wr_go  = wr_en && w_wr_ok;
    // A same-cycle fill to the read location wins over the stored word.
    assign w_bypass = w_wr_go && w_rd_ok && (w_wr_idx == w_rd_idx) && (wr_set == set_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    r_mem[w][s] <= '0;
                end
            end
        end else if (w_wr_go) begin
            r_mem[w_wr_idx][wr_set] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_oh_err <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_wr_ok;
            r_valid  <= req_valid;
            r_oh_err <= req_valid && !w_rd_ok;
            if (req_valid) begin
                if (!w_rd_ok) begin
                    r_data <= '0;
                end else if (w_bypass) begin
                    r_data <= wr_data;
                end else begin
                    r_data <= r_mem[w_rd_idx][set_idx];
                end
            end
        end
    end

    assign dataOut    = r_data;
    assign data_valid = r_valid;
    assign onehot_err = r_oh_err;
    assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_cache_data_fetcher.sv
// Directed bench for cache_data_fetcher: driver pushes expected responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cache_data_fetcher;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [3:0]  set_idx;
  logic [3:0]  targetWay;
  logic [31:0] dataOut;
  logic        data_valid;
  logic        onehot_err;
  logic        wr_en;
  logic [3:0]  wr_way;
  logic [3:0]  wr_set;
  logic [31:0] wr_data;
  logic        wr_err;

  logic [32:0] exp_q[$];   // {onehot_err, dataOut}
  logic        wr_q[$];
  logic [31:0] last_data;
  int          errors;
  int          checks;

  cache_data_fetcher dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .set_idx    (set_idx),
    .targetWay  (targetWay),
    .dataOut    (dataOut),
    .data_valid (data_valid),
    .onehot_err (onehot_err),
    .wr_en      (wr_en),
    .wr_way     (wr_way),
    .wr_set     (wr_set),
    .wr_data    (wr_data),
    .wr_err     (wr_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_idle();
    req_valid = 1'b0;
    wr_en     = 1'b0;
    targetWay = '0;
    set_idx   = '0;
    wr_way    = '0;
    wr_set    = '0;
    wr_data   = '0;
  endtask

  task automatic step(input logic rv, input logic [3:0] tw, input logic [3:0] si,
                      input logic we, input logic [3:0] ww, input logic [3:0] ws,
                      input logic [31:0] wd, input logic [31:0] exp_d,
                      input logic exp_e, input logic exp_we);
    req_valid = rv;
    targetWay = tw;
    set_idx   = si;
    wr_en     = we;
    wr_way    = ww;
    wr_set    = ws;
    wr_data   = wd;
    if (rv) exp_q.push_back({exp_e, exp_d});
    if (we && exp_we) wr_q.push_back(1'b1);
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic rd(input logic [3:0] tw, input logic [3:0] si, input logic [31:0] exp_d,
                    input logic exp_e);
    step(1'b1, tw, si, 1'b0, 4'b0000, 4'd0, 32'd0, exp_d, exp_e, 1'b0);
  endtask

  task automatic wr(input logic [3:0] ww, input logic [3:0] ws, input logic [31:0] wd,
                    input logic exp_we);
    step(1'b0, 4'b0000, 4'd0, 1'b1, ww, ws, wd, 32'd0, 1'b0, exp_we);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      last_data = '0;
    end else begin
      if (data_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_response: dataOut=%h onehot_err=%b with nothing expected", dataOut, onehot_err);
        end else begin
          e = exp_q.pop_front();
          if ({onehot_err, dataOut} !== e) begin
            errors++;
            $display("FAIL response: got err=%b data=%h, want err=%b data=%h", onehot_err, dataOut, e[32], e[31:0]);
          end
          last_data = e[31:0];
        end
      end else begin
        checks++;
        if (onehot_err !== 1'b0 || dataOut !== last_data) begin
          errors++;
          $display("FAIL idle_hold: got err=%b data=%h, want err=0 data=%h", onehot_err, dataOut, last_data);
        end
      end
      if (wr_err) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr_err: wr_err=1 with none expected");
        end else begin
          void'(wr_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    checks++;
    if (dataOut !== 32'd0 || data_valid !== 1'b0 || onehot_err !== 1'b0 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: got data=%h dv=%b oe=%b we=%b, want all 0", name, dataOut, data_valid, onehot_err, wr_err);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    last_data = '0;
    drive_idle();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // first read after reset returns the cleared word
    rd(4'b0001, 4'd3, 32'h0, 1'b0);

    // write then read back
    wr(4'b0100, 4'd5, 32'hDEADBEEF, 1'b0);
    rd(4'b0100, 4'd5, 32'hDEADBEEF, 1'b0);

    // same-cycle read/write to the same location bypasses
    step(1'b1, 4'b1000, 4'd7, 1'b1, 4'b1000, 4'd7, 32'h12345678, 32'h12345678, 1'b0, 1'b0);
    rd(4'b1000, 4'd7, 32'h12345678, 1'b0);

    // bad one-hot reads and a bad one-hot write
    rd(4'b0110, 4'd5, 32'h0, 1'b1);
    rd(4'b0000, 4'd5, 32'h0, 1'b1);
    wr(4'b0011, 4'd5, 32'hFFFF_FFFF, 1'b1);
    idle_cycles(2);
    rd(4'b0001, 4'd5, 32'h0, 1'b0);
    rd(4'b0010, 4'd5, 32'h0, 1'b0);
    rd(4'b0100, 4'd5, 32'hDEADBEEF, 1'b0);

    // fill set 0 then four back-to-back reads
    wr(4'b0001, 4'd0, 32'd1, 1'b0);
    wr(4'b0010, 4'd0, 32'd2, 1'b0);
    wr(4'b0100, 4'd0, 32'd3, 1'b0);
    wr(4'b1000, 4'd0, 32'd4, 1'b0);
    rd(4'b0001, 4'd0, 32'd1, 1'b0);
    rd(4'b0010, 4'd0, 32'd2, 1'b0);
    rd(4'b0100, 4'd0, 32'd3, 1'b0);
    rd(4'b1000, 4'd0, 32'd4, 1'b0);

    // independent read and write in the same cycle
    step(1'b1, 4'b0001, 4'd0, 1'b1, 4'b0001, 4'd1, 32'h0000_00AA, 32'd1, 1'b0, 1'b0);
    rd(4'b0001, 4'd1, 32'h0000_00AA, 1'b0);
    step(1'b1, 4'b0010, 4'd15, 1'b1, 4'b0100, 4'd15, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    rd(4'b0100, 4'd15, 32'hCAFE_F00D, 1'b0);
    idle_cycles(2);

    // request in flight when reset asserts is dropped
    req_valid = 1'b1;
    targetWay = 4'b0100;
    set_idx   = 4'd5;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_midflight");
    drive_idle();
    @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_cycles(2);
    rd(4'b0100, 4'd5, 32'h0, 1'b0);
    rd(4'b1000, 4'd7, 32'h0, 1'b0);
    rd(4'b0001, 4'd0, 32'h0, 1'b0);
    rd(4'b0001, 4'd1, 32'h0, 1'b0);
    idle_cycles(3);

    // final report
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_responses: %0d outstanding, want 0", exp_q.size());
    end
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL missing_wr_err: %0d outstanding, want 0", wr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
